// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types and helpers for the writeback path
package rf_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rtl/rf_wb_ctrl_if.sv - producer handshakes, register-file write port and status bundle
interface rf_wb_ctrl_if #(
  parameter int DEPTH = 4
);
  import rf_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic              ld_valid;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              ld_ready;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;
  logic              write;
  logic [REG_AW-1:0] writeregsel;
  logic [XLEN-1:0]   writedata;
  logic [NUM_REGS-1:0] pending;
  logic [CW-1:0]     count;

  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    input  ld_ready, alu_ready, write, writeregsel, writedata, pending, count
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    output ld_ready, alu_ready, write, writeregsel, writedata, pending, count
  );

endinterface

// File: rtl/rf_wb_ctrl_fifo.sv
// rtl/rf_wb_ctrl_fifo.sv - circular writeback queue with two ordered enqueue ports and one pop
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push0,
  input  wb_entry_t             i_entry0,
  input  logic                  i_push1,
  input  wb_entry_t             i_entry1,
  input  logic                  i_pop,
  output wb_entry_t [DEPTH-1:0] o_entries,
  output logic [DEPTH-1:0]      o_valid,
  output logic [PW-1:0]         o_head_ptr,
  output logic [CW-1:0]         o_count
);

  // Explicit wrap so DEPTH need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic [PW-1:0] w_tail1;
  logic [PW-1:0] w_tail_nxt;
  logic          w_pop;

  // Port 1 lands behind port 0 so the load entry is always the older one
  assign w_tail1    = i_push0 ? ptr_inc(r_tail) : r_tail;
  assign w_tail_nxt = i_push1 ? ptr_inc(w_tail1) : w_tail1;
  assign w_pop      = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end
      if (i_push0) begin
        r_mem[r_tail]   <= i_entry0;
        r_valid[r_tail] <= 1'b1;
      end
      if (i_push1) begin
        r_mem[w_tail1]   <= i_entry1;
        r_valid[w_tail1] <= 1'b1;
      end
      r_tail  <= w_tail_nxt;
      r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(w_pop);
    end
  end

  assign o_entries  = r_mem;
  assign o_valid    = r_valid;
  assign o_head_ptr = r_head;
  assign o_count    = r_count;

endmodule

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - register-file write-port controller merging load and ALU writebacks
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  rf_wb_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic                  w_ld_ready;
  logic                  w_alu_ready;
  logic                  w_ld_push;
  logic                  w_alu_push;
  logic                  w_write;
  wb_entry_t             w_ld_entry;
  wb_entry_t             w_alu_entry;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_valid;
  logic [PW-1:0]         w_head_ptr;
  logic [CW-1:0]         w_count;
  logic [NUM_REGS-1:0]   w_pending;

  // Readiness looks only at occupancy; the drain never feeds back into it
  assign w_ld_ready  = (w_count <= CW'(DEPTH - 1));
  assign w_alu_ready = (w_count <= CW'(DEPTH - 2)) ||
                       ((w_count == CW'(DEPTH - 1)) && !bus.ld_valid);

  // r0 writes finish the handshake but never occupy a slot
  assign w_ld_push   = bus.ld_valid  && w_ld_ready  && (bus.ld_rd  != '0);
  assign w_alu_push  = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
  assign w_ld_entry  = '{rd: bus.ld_rd,  data: bus.ld_data};
  assign w_alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push0    (w_ld_push),
    .i_entry0   (w_ld_entry),
    .i_push1    (w_alu_push),
    .i_entry1   (w_alu_entry),
    .i_pop      (w_write),
    .o_entries  (w_entries),
    .o_valid    (w_valid),
    .o_head_ptr (w_head_ptr),
    .o_count    (w_count)
  );

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) w_pending = w_pending | reg_onehot(w_entries[i].rd);
    end
    w_pending[0] = 1'b0;
  end

  assign w_head  = w_entries[w_head_ptr];
  assign w_write = (w_count != '0);

  assign bus.ld_ready    = w_ld_ready;
  assign bus.alu_ready   = w_alu_ready;
  assign bus.write       = w_write;
  assign bus.writeregsel = w_write ? w_head.rd   : '0;
  assign bus.writedata   = w_write ? w_head.data : '0;
  assign bus.pending     = w_pending;
  assign bus.count       = w_count;

endmodule
